// File: rtl/uart_cmd_engine_if.sv
// Pin-level bundle between the UART command engine and the board:
// serial lines plus the channel bank and status strobes.
`timescale 1ns/1ps
interface uart_cmd_engine_if #(
  parameter int N_CH = 8
);
  logic            rx;
  logic            tx;
  logic [N_CH-1:0] led;
  logic            cmd_done;
  logic            err;
  logic            busy;

  modport master (input rx, output tx, output led, output cmd_done, output err, output busy);
  modport slave  (output rx, input tx, input led, input cmd_done, input err, input busy);
endinterface

// File: rtl/uart_cmd_engine.sv
// Full-duplex 8N1 UART with a two-byte command parser driving N_CH output
// channels; every accepted command is answered with one byte on tx.
`timescale 1ns/1ps
module uart_cmd_engine #(
  parameter int CLKS_PER_BIT = 8,
  parameter int N_CH         = 8,
  parameter int TIMEOUT_CLKS = 4096
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_engine_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0] ACK = 8'h55;
  localparam logic [7:0] NAK = 8'hEE;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_STOP, T_GAP} tx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT_ARG, P_EXEC, P_RESP} p_state_t;

  // Synchroniser stage p0/p1; p2 keeps the previous synchronised level for edge detection
  logic rx_p0, rx_p1, rx_p2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CNT_W'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (rx_p2 && !rx_p1) rx_state_n = R_START;
      end
      R_START: if (rx_cnt == HALF_LAST) begin
        // A start bit that is high again at mid-bit was a glitch
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_p1 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_p1, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = R_STOP;
      end
      R_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_valid_n = rx_p1;
        rx_ferr_n  = !rx_p1;
        rx_state_n = R_IDLE;
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  p_state_t         p_state, p_state_n;
  logic [7:0]       op, op_n, ch, ch_n, resp, resp_n, led_byte;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic [N_CH-1:0]  led, led_n;
  logic             tx_go, tx_go_n, cmd_done, cmd_done_n, err, err_n;
  logic             tx_done;

  always_comb begin
    led_byte = '0;
    led_byte[N_CH-1:0] = led;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state  <= P_IDLE;
      op       <= '0;
      ch       <= '0;
      tmo      <= '0;
      resp     <= '0;
      tx_go    <= 1'b0;
      led      <= '0;
      cmd_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      p_state  <= p_state_n;
      op       <= op_n;
      ch       <= ch_n;
      tmo      <= tmo_n;
      resp     <= resp_n;
      tx_go    <= tx_go_n;
      led      <= led_n;
      cmd_done <= cmd_done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    p_state_n  = p_state;
    op_n       = op;
    ch_n       = ch;
    tmo_n      = tmo;
    resp_n     = resp;
    tx_go_n    = 1'b0;
    led_n      = led;
    cmd_done_n = 1'b0;
    err_n      = rx_ferr;
    case (p_state)
      P_IDLE: if (rx_valid) begin
        op_n = rx_shift;
        case (rx_shift)
          8'hA1, 8'hA2, 8'hA3: begin
            tmo_n     = '0;
            p_state_n = P_WAIT_ARG;
          end
          8'hB1, 8'hC1: p_state_n = P_EXEC;
          default: begin
            resp_n    = NAK;
            err_n     = 1'b1;
            tx_go_n   = 1'b1;
            p_state_n = P_RESP;
          end
        endcase
      end
      P_WAIT_ARG: begin
        if (rx_valid) begin
          ch_n      = rx_shift;
          p_state_n = P_EXEC;
        end else if (rx_ferr || tmo == TMO_LAST) begin
          resp_n    = NAK;
          err_n     = 1'b1;
          tx_go_n   = 1'b1;
          p_state_n = P_RESP;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      P_EXEC: begin
        p_state_n  = P_RESP;
        tx_go_n    = 1'b1;
        resp_n     = ACK;
        cmd_done_n = 1'b1;
        if (rx_valid) err_n = 1'b1;
        if (op == 8'hB1) begin
          resp_n = led_byte;
        end else if (op == 8'hC1) begin
          led_n = '0;
        end else if (ch >= 8'(N_CH)) begin
          resp_n     = NAK;
          cmd_done_n = 1'b0;
          err_n      = 1'b1;
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            if (ch == 8'(i)) begin
              if (op == 8'hA1)      led_n[i] = 1'b1;
              else if (op == 8'hA2) led_n[i] = 1'b0;
              else                  led_n[i] = ~led[i];
            end
          end
        end
      end
      P_RESP: begin
        // No queueing: a byte finishing while the reply is out is lost
        if (rx_valid) err_n = 1'b1;
        if (tx_done) p_state_n = P_IDLE;
      end
      default: p_state_n = P_IDLE;
    endcase
  end

  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_line, tx_line_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CNT_W'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    tx_done    = 1'b0;
    case (tx_state)
      T_IDLE: begin
        tx_cnt_n = '0;
        if (tx_go) begin
          tx_shift_n = resp;
          tx_line_n  = 1'b0;
          tx_state_n = T_START;
        end
      end
      T_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_line_n  = tx_shift[0];
        tx_state_n = T_DATA;
      end
      T_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_shift_n = {1'b0, tx_shift[7:1]};
        tx_bit_n   = tx_bit + 3'd1;
        if (tx_bit == 3'd7) begin
          tx_line_n  = 1'b1;
          tx_state_n = T_STOP;
        end else begin
          tx_line_n = tx_shift[1];
        end
      end
      T_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = T_GAP;
      end
      T_GAP: if (tx_cnt == BIT_LAST) begin
        // Idle bit-time guarantees spacing before the next reply frame
        tx_cnt_n   = '0;
        tx_state_n = T_IDLE;
        tx_done    = 1'b1;
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  assign bus.tx       = tx_line;
  assign bus.led      = led;
  assign bus.cmd_done = cmd_done;
  assign bus.err      = err;
  assign bus.busy     = (p_state != P_IDLE) || (tx_state != T_IDLE);
endmodule
